// File: rtl/axis_frame_source.sv
// axis_frame_source
//
// AXI-Stream frame transmitter. One accepted start request produces a
// single frame of frame_len beats whose data increments from the captured
// seed. The final beat carries tlast and the captured last_tstrb; every
// other beat carries full strobes. Completion is reported with a one-cycle
// done pulse and a running frame counter. An optional idle gap follows
// each frame before another start is accepted.
//
// Every output is driven straight from a register, so tready never
// reaches an output combinationally.
//
// Ports
//   m01_axis_aclk     in   clock, rising edge
//   m01_axis_areset   in   synchronous reset, active high
//   start             in   frame request, sampled only while idle
//   frame_len         in   beats in the frame (captured with start)
//   seed              in   data of beat 0 (captured with start)
//   last_tstrb        in   strobe for the final beat (captured with start)
//   busy              out  high whenever the FSM is not idle
//   done              out  one-cycle pulse after the last beat is accepted
//   len_err           out  one-cycle pulse when a zero-length start is rejected
//   frame_count       out  completed frames, wraps modulo 2^16
//   m01_axis_tready   in   downstream ready
//   m01_axis_tdata    out  beat data
//   m01_axis_tstrb    out  byte strobes
//   m01_axis_tvalid   out  beat valid
//   m01_axis_tlast    out  final beat of the frame
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; zero-length requests rejected here
// SEND    | presenting beats; index advances only on a handshake
// GAP     | post-frame idle time, GAP_CYCLES cycles, then back to IDLE

module axis_frame_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 12,
  parameter int GAP_CYCLES = 0
) (
  input  logic                    m01_axis_aclk,
  input  logic                    m01_axis_areset,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    frame_len,
  input  logic [DATA_WIDTH-1:0]   seed,
  input  logic [DATA_WIDTH/8-1:0] last_tstrb,
  output logic                    busy,
  output logic                    done,
  output logic                    len_err,
  output logic [15:0]             frame_count,
  input  logic                    m01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Gap timer counts down to zero; loading G-1 yields exactly G cycles in GAP.
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [STRB_WIDTH-1:0]  tstrb_q, tstrb_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   len_err_q, len_err_d;
  logic [15:0]            frame_count_q, frame_count_d;
  // Beats still to be presented after the one currently on the bus.
  logic [LEN_WIDTH-1:0]   beats_left_q, beats_left_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [STRB_WIDTH-1:0]  last_strb_q, last_strb_d;
  logic                   handshake;

  assign handshake = tvalid_q && m01_axis_tready;

  always_ff @(posedge m01_axis_aclk) begin
    if (m01_axis_areset) begin
      state_q       <= ST_IDLE;
      tdata_q       <= '0;
      tstrb_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      len_err_q     <= 1'b0;
      frame_count_q <= '0;
      beats_left_q  <= '0;
      gap_cnt_q     <= '0;
      last_strb_q   <= '0;
    end else begin
      state_q       <= state_d;
      tdata_q       <= tdata_d;
      tstrb_q       <= tstrb_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      len_err_q     <= len_err_d;
      frame_count_q <= frame_count_d;
      beats_left_q  <= beats_left_d;
      gap_cnt_q     <= gap_cnt_d;
      last_strb_q   <= last_strb_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tdata_d       = tdata_q;
    tstrb_d       = tstrb_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    len_err_d     = 1'b0;
    frame_count_d = frame_count_q;
    beats_left_d  = beats_left_q;
    gap_cnt_d     = gap_cnt_q;
    last_strb_d   = last_strb_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (frame_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            state_d      = ST_SEND;
            busy_d       = 1'b1;
            tvalid_d     = 1'b1;
            tdata_d      = seed;
            last_strb_d  = last_tstrb;
            beats_left_d = frame_len - LEN_WIDTH'(1);
            // A one-beat frame is its own last beat.
            if (frame_len == LEN_WIDTH'(1)) begin
              tlast_d = 1'b1;
              tstrb_d = last_tstrb;
            end else begin
              tlast_d = 1'b0;
              tstrb_d = '1;
            end
          end
        end
      end

      ST_SEND: begin
        if (handshake) begin
          if (tlast_q) begin
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            if (GAP_CYCLES > 0) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            tdata_d      = tdata_q + DATA_WIDTH'(1);
            beats_left_d = beats_left_q - LEN_WIDTH'(1);
            if (beats_left_q == LEN_WIDTH'(1)) begin
              tlast_d = 1'b1;
              tstrb_d = last_strb_q;
            end else begin
              tlast_d = 1'b0;
              tstrb_d = '1;
            end
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign len_err         = len_err_q;
  assign frame_count     = frame_count_q;
  assign m01_axis_tdata  = tdata_q;
  assign m01_axis_tstrb  = tstrb_q;
  assign m01_axis_tvalid = tvalid_q;
  assign m01_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Testbench for axis_frame_source with a two-cycle post-frame gap.
// Expected beats come from arithmetic on the request (seed + index,
// strobe pattern, last-beat position); outputs are sampled on the
// falling edge and inputs are driven there as well.

module tb_axis_frame_source;

  localparam int DW  = 32;
  localparam int LW  = 12;
  localparam int SW  = DW / 8;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [DW-1:0] seed = '0;
  logic [SW-1:0] last_tstrb = '0;
  logic          tready = 1'b0;

  logic          busy, done, len_err;
  logic [15:0]   frame_count;
  logic [DW-1:0] tdata;
  logic [SW-1:0] tstrb;
  logic          tvalid, tlast;

  int n_total = 0;
  int n_pass  = 0;
  int exp_fc  = 0;

  bit bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  axis_frame_source #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .GAP_CYCLES(GAP)
  ) u_dut (
    .m01_axis_aclk  (clk),
    .m01_axis_areset(areset),
    .start          (start),
    .frame_len      (frame_len),
    .seed           (seed),
    .last_tstrb     (last_tstrb),
    .busy           (busy),
    .done           (done),
    .len_err        (len_err),
    .frame_count    (frame_count),
    .m01_axis_tready(tready),
    .m01_axis_tdata (tdata),
    .m01_axis_tstrb (tstrb),
    .m01_axis_tvalid(tvalid),
    .m01_axis_tlast (tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc < 6) ? bp_pat[cyc] : 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Requests one frame from the idle state and follows it through the
  // done cycle and the gap. With hold set, start stays high afterwards.
  task automatic run_frame(input int len, input logic [DW-1:0] sd,
                           input logic [SW-1:0] ls, input int mode, input bit hold);
    int idx;
    int cyc;
    bit stall;
    logic [DW-1:0] ed, pd;
    logic [SW-1:0] es, ps;
    logic el, pl;
    start      = 1'b1;
    frame_len  = LW'(len);
    seed       = sd;
    last_tstrb = ls;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("first_busy", busy, 1);
    idx = 0; cyc = 0; stall = 0;
    pd = '0; ps = '0; pl = 1'b0;
    while (idx < len && cyc < 200) begin
      ed = sd + DW'(idx);
      el = (idx == len - 1);
      es = el ? ls : '1;
      chk("tvalid", tvalid, 1);
      chk("tdata", tdata, ed);
      chk("tstrb", tstrb, es);
      chk("tlast", tlast, el);
      chk("busy_send", busy, 1);
      chk("done_early", done, 0);
      if (stall) chk("stall_hold", {tdata, tstrb, tlast}, {pd, ps, pl});
      pd = tdata; ps = tstrb; pl = tlast;
      tready = pick_ready(mode, cyc);
      stall  = !tready;
      if (tready) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("frame_beats", idx, len);
    exp_fc++;
    chk("done_pulse", done, 1);
    chk("tvalid_after", tvalid, 0);
    chk("tlast_after", tlast, 0);
    chk("frame_count", frame_count, 16'(exp_fc));
    chk("busy_done_cycle", busy, (GAP > 0));
    for (int g = 1; g <= GAP; g++) begin
      @(negedge clk);
      chk("gap_busy", busy, (g < GAP));
      chk("gap_tvalid", tvalid, 0);
      chk("gap_done", done, 0);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tstrb", tstrb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_frame_count", frame_count, 0);
    areset = 1'b0;
    @(negedge clk);

    // Basic frame, continuous ready
    run_frame(4, 32'h0000_0100, 4'h3, 0, 1'b0);

    // Backpressure pattern 1,0,0,1,0,1
    run_frame(3, 32'h0000_2000, 4'h7, 1, 1'b0);

    // Data wrap-around
    run_frame(3, 32'hFFFF_FFFE, 4'h1, 0, 1'b0);

    // Single-beat frame
    run_frame(1, 32'hDEAD_BEEF, 4'h5, 0, 1'b0);

    // Zero-length request is rejected
    start = 1'b1; frame_len = '0; seed = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    chk("len_err_pulse", len_err, 1);
    chk("len_err_busy", busy, 0);
    chk("len_err_tvalid", tvalid, 0);
    @(negedge clk);
    chk("len_err_one_cycle", len_err, 0);
    chk("len_err_no_done", done, 0);
    chk("len_err_busy2", busy, 0);
    chk("len_err_fc", frame_count, 16'(exp_fc));

    // Start held high throughout: ignored during SEND, accepted at the
    // earliest legal edge after the gap (first beat 3 cycles after done).
    run_frame(5, 32'h0000_5000, 4'hC, 2, 1'b1);
    run_frame(2, 32'h0000_6000, 4'h8, 0, 1'b0);

    // Randomized frames against the arithmetic model
    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(1, 20)), DW'($urandom), SW'($urandom_range(0, 15)), 2, 1'b0);
    end

    // Reset during beat 2 of an 8-beat frame
    tready = 1'b1;
    start = 1'b1; frame_len = LW'(8); seed = 32'hA5A5_0000; last_tstrb = 4'h1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid_beat0", tdata, 32'hA5A5_0000);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_beat2", tdata, 32'hA5A5_0002);
    areset = 1'b1;
    @(negedge clk);
    chk("abort_tvalid", tvalid, 0);
    chk("abort_tlast", tlast, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_frame_count", frame_count, 0);
    chk("abort_tdata", tdata, 0);
    areset = 1'b0;
    exp_fc = 0;
    @(negedge clk);
    run_frame(3, 32'hA5A5_0000, 4'h1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axis_frame_source.md
# axis_frame_source

AXI-Stream frame transmitter that generates fixed-pattern data frames and drives them into the slave stream port of the memory subsystem (`s01_axis_*` of the memory wrapper). It serves as the write-side stimulus and traffic engine. A single start pulse produces one frame of `frame_len` beats with incrementing data, full backpressure compliance and `tlast` on the final beat, and reports completion to a control FSM.

## Interface
Parameters:
- `DATA_WIDTH`, 32, stream data width in bits (multiple of 8)
- `LEN_WIDTH`, 12, width of the frame-length field; maximum frame is 2^LEN_WIDTH-1 beats
- `GAP_CYCLES`, 0, idle cycles enforced after each frame before the next start is accepted

Ports:
- `m01_axis_aclk` in 1: single clock. All logic is rising-edge.
- `m01_axis_areset` in 1: synchronous, active-high reset.
- `start` in 1: frame request; sampled only in IDLE.
- `frame_len` in LEN_WIDTH: beats in the frame; captured with `start`.
- `seed` in DATA_WIDTH: data of beat 0; captured with `start`.
- `last_tstrb` in DATA_WIDTH/8: strobe for the final beat; captured with `start`.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse on frame completion.
- `len_err` out 1: one-cycle pulse when a start with `frame_len`==0 is rejected.
- `frame_count` out 16: number of completed frames; wraps modulo 2^16.
- `m01_axis_tready` in 1: downstream ready.
- `m01_axis_tdata` out DATA_WIDTH: beat data.
- `m01_axis_tstrb` out DATA_WIDTH/8: byte strobes.
- `m01_axis_tvalid` out 1: beat valid.
- `m01_axis_tlast` out 1: final beat of the frame.

## Operation
- FSM states:
  - IDLE -> SEND on `start` with `frame_len`!=0.
  - SEND -> GAP on handshake of the last beat when GAP_CYCLES>0; otherwise SEND -> IDLE.
  - GAP -> IDLE after GAP_CYCLES cycles.
- `start` in IDLE with `frame_len`==0: `len_err` pulses the next cycle. No beats, no `done`, state stays IDLE.
- `start` is ignored outside IDLE. No queuing.
- Beat i (0-based): `tdata` = `seed` + i, modulo 2^DATA_WIDTH. Wrap-around is silent.
- `tstrb` is all ones on every beat except the last, which carries the captured `last_tstrb`.
- `tlast` is high only on beat `frame_len`-1. A 1-beat frame has `tlast` on beat 0 with `last_tstrb`.
- A handshake occurs when `tvalid` && `tready`. The beat index advances only on a handshake.
- While `tvalid`=1 and `tready`=0, `tdata`, `tstrb`, `tlast` and `tvalid` hold stable. `tvalid` never drops without a handshake.
- `frame_count` increments in the same cycle `done` is high.
- Reset mid-frame: the frame is aborted. All outputs return to reset values on the next edge, with no `done` and no `frame_count` increment.
- Reset values: `tvalid`=0, `tlast`=0, `tdata`=0, `tstrb`=0, `busy`=0, `done`=0, `len_err`=0, `frame_count`=0, state IDLE.

## Timing
- All outputs are registered. No combinational path from `tready` to any output.
- `start` sampled at edge N -> `tvalid`=1 with beat 0 from cycle N+1, `busy`=1 from N+1.
- With `tready` held high: one beat per cycle. The last beat is accepted at cycle N+`frame_len`.
- Last-beat handshake at edge M:
  - `tvalid`=0, `tlast`=0 and `done`=1 in cycle M+1.
  - GAP_CYCLES=0: `busy`=0 in M+1, and a `start` sampled at M+1 is accepted (back-to-back frames, one idle cycle between them).
  - GAP_CYCLES=G>0: `busy` stays high through cycle M+G and falls in M+G+1. The earliest accepted `start` is at edge M+G+1.
- `len_err` rises the cycle after the rejected `start` and lasts one cycle.

## Test plan
- **Basic frame:** reset, then `start` with `frame_len`=4, `seed`=0x100, `last_tstrb`=0x3, `tready`=1 -> beats 0x100, 0x101, 0x102, 0x103 on consecutive cycles, `tstrb` F,F,F,3, `tlast` only on 0x103, `done` one cycle later, `frame_count`=1.
- **Backpressure:** `frame_len`=3, `tready` toggled 1,0,0,1,0,1 -> exactly 3 handshakes, data held stable across every stall, no duplicated or skipped beat, `done` after the third handshake.
- **Boundaries:**
  - `seed`=0xFFFFFFFE, `frame_len`=3 -> data FFFFFFFE, FFFFFFFF, 00000000.
  - `frame_len`=1 -> a single beat with `tlast`=1.
  - `frame_len`=0 -> `len_err` pulse only, `busy` stays 0.
- **Start while busy plus gap:** GAP_CYCLES=2, a second `start` during SEND is ignored, and a `start` held high continuously -> second frame begins exactly 3 cycles after `done`. `frame_count`=2 at the end.
- **Reset mid-frame:** assert `m01_axis_areset` on beat 2 of an 8-beat frame -> next cycle `tvalid`=0, `busy`=0, `frame_count`=0, no `done`. A following `start` yields a clean frame starting at `seed`.
